system_memory_v4: RTL

//  Grid state memory for the Life engine, successor to the single-bit serial memory.

---
 rtl/system_memory_v4.sv | 133 +++++++++++++
 1 files changed

// File: rtl/system_memory_v4.sv
// Life grid state memory: an input shift register (system_mem_out) and a shadow output shift register.
// Both load from grid_in (run) or the serial lane (load); define OUTPUT_ROTATE_EN for rotating output dumps.
module system_memory_v4 #(
  parameter  int GRID_ROWS  = 8,
  parameter  int GRID_COLS  = 8,
  parameter  int LANE_WIDTH = 1,
  parameter  int GEN_WIDTH  = 16,
  localparam int DATA_SIZE  = GRID_ROWS * GRID_COLS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_SIZE-1:0]  grid_in,
  input  logic                  run_mode,
  input  logic                  load_mode,
  input  logic                  output_mode,
  input  logic [LANE_WIDTH-1:0] serial_in,
  input  logic                  serial_in_valid,
  output logic [DATA_SIZE-1:0]  system_mem_out,
  output logic [LANE_WIDTH-1:0] serial_out,
  output logic                  serial_out_valid,
  output logic                  load_done,
  output logic                  output_done,
  output logic [GEN_WIDTH-1:0]  gen_count
);

  localparam int BEATS = DATA_SIZE / LANE_WIDTH;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  if ((DATA_SIZE % LANE_WIDTH) != 0) begin : g_lane_check
    $error("system_memory_v4: LANE_WIDTH must divide GRID_ROWS*GRID_COLS");
  end

  typedef enum logic [1:0] {
    MODE_IDLE,
    MODE_RUN,
    MODE_LOAD,
    MODE_OUT
  } mode_t;

  logic [DATA_SIZE-1:0]  r_input_sr;
  logic [DATA_SIZE-1:0]  r_output_sr;
  logic [CW-1:0]         r_beat;
  mode_t                 r_prev_mode;
  logic [LANE_WIDTH-1:0] r_serial_out;
  logic                  r_serial_out_valid;
  logic                  r_load_done;
  logic                  r_output_done;
  logic [GEN_WIDTH-1:0]  r_gen_count;

  mode_t                 w_mode;
  logic [CW-1:0]         w_beat;
  logic                  w_last;
  logic [CW-1:0]         w_beat_next;
  logic [DATA_SIZE-1:0]  w_input_shift;
  logic [DATA_SIZE-1:0]  w_output_load;
  logic [DATA_SIZE-1:0]  w_output_shift;
  logic [LANE_WIDTH-1:0] w_top_lane;

  always_comb begin
    w_mode = MODE_IDLE;
    if (run_mode)         w_mode = MODE_RUN;
    else if (load_mode)   w_mode = MODE_LOAD;
    else if (output_mode) w_mode = MODE_OUT;
  end

  // A mode switch abandons any partial transfer: the beat count restarts at 0.
  assign w_beat      = (w_mode != r_prev_mode) ? '0 : r_beat;
  assign w_last      = (w_beat == LAST_BEAT);
  assign w_beat_next = w_last ? '0 : (w_beat + CW'(1));

  assign w_top_lane    = r_output_sr[DATA_SIZE-1 -: LANE_WIDTH];
  assign w_input_shift = DATA_SIZE'({r_input_sr, serial_in});
  assign w_output_load = DATA_SIZE'({r_output_sr, serial_in});
`ifdef OUTPUT_ROTATE_EN
  assign w_output_shift = DATA_SIZE'({r_output_sr, w_top_lane});
`else
  assign w_output_shift = DATA_SIZE'({r_output_sr, {LANE_WIDTH{1'b0}}});
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_input_sr         <= '0;
      r_output_sr        <= '0;
      r_beat             <= '0;
      r_prev_mode        <= MODE_IDLE;
      r_serial_out       <= '0;
      r_serial_out_valid <= 1'b0;
      r_load_done        <= 1'b0;
      r_output_done      <= 1'b0;
      r_gen_count        <= '0;
    end else begin
      r_prev_mode        <= w_mode;
      r_serial_out_valid <= 1'b0;
      r_load_done        <= 1'b0;
      r_output_done      <= 1'b0;
      case (w_mode)
        MODE_RUN: begin
          r_input_sr  <= grid_in;
          r_output_sr <= grid_in;
          r_beat      <= '0;
          r_gen_count <= r_gen_count + GEN_WIDTH'(1);
        end
        MODE_LOAD: begin
          if (serial_in_valid) begin
            r_input_sr  <= w_input_shift;
            r_output_sr <= w_output_load;
            r_beat      <= w_beat_next;
            r_load_done <= w_last;
          end else begin
            r_beat <= w_beat;
          end
        end
        MODE_OUT: begin
          r_serial_out       <= w_top_lane;
          r_serial_out_valid <= 1'b1;
          r_output_sr        <= w_output_shift;
          r_beat             <= w_beat_next;
          r_output_done      <= w_last;
        end
        default: ;
      endcase
    end
  end

  assign system_mem_out   = r_input_sr;
  assign serial_out       = r_serial_out;
  assign serial_out_valid = r_serial_out_valid;
  assign load_done        = r_load_done;
  assign output_done      = r_output_done;
  assign gen_count        = r_gen_count;

endmodule
